// File: rtl/key_matrix_scan_if.sv
// Signal bundle between the 4x4 key matrix scanner and the board:
// column drive and row sense, plus the debounced key result.
interface key_matrix_scan_if;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_value;
    logic       key_flag;
    logic       key_valid;

    modport master (
        input  key_row,
        output key_col,
        output key_value,
        output key_flag,
        output key_valid
    );

    modport slave (
        output key_row,
        input  key_col,
        input  key_value,
        input  key_flag,
        input  key_valid
    );
endinterface

// File: rtl/key_matrix_scan.sv
// 4x4 active-low key matrix scanner. It builds a 16-bit frame, one column per slot,
// debounces whole frames, and reports the confirmed key code with a one-cycle strobe.
module key_matrix_scan #(
    parameter logic [24:0] SCAN_TIME    = 25'd50_000,
    parameter logic [7:0]  DEBOUNCE_CNT = 8'd20
) (
    input  logic              clk,
    input  logic              rst,
    key_matrix_scan_if.master kb
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PRESS_DB = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;
    localparam logic [1:0] REL_DB   = 2'd3;

    logic [3:0]  row_meta;
    logic [3:0]  row_sync;
    logic [24:0] scan_cnt;
    logic [1:0]  col;
    logic [1:0]  col_next;
    logic        slot_end;
    logic [15:0] frame;
    logic        frame_done;
    logic [1:0]  state;
    logic [15:0] cand;
    logic [7:0]  cnt;
    logic [3:0]  low_idx;
    logic [3:0]  low_code;

    assign slot_end = (scan_cnt == SCAN_TIME - 25'd1);
    assign col_next = slot_end ? col + 2'd1 : col;

    // Rows idle high through the pull-ups, so the synchronizer resets to "nothing pressed".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            // NOTE: non-blocking so each flop samples the previous stage's old value.
            row_meta <= kb.key_row;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt   <= '0;
            col        <= 2'd0;
            kb.key_col <= 4'b1110;
            frame      <= '0;
            frame_done <= 1'b0;
        end else begin
            scan_cnt   <= slot_end ? 25'd0 : scan_cnt + 25'd1;
            col        <= col_next;
            kb.key_col <= ~(4'b0001 << col_next);
            frame_done <= slot_end && (col == 2'd3);
            // Sampling at the end of the slot gives the row lines the whole slot to settle.
            if (slot_end)
                frame[{col, 2'b00} +: 4] <= ~row_sync;
        end
    end

    // Lowest set frame bit wins; bit index is col*4+row, the reported code is row*4+col.
    always_comb begin
        // NOTE: default first so every path assigns low_idx and no latch is inferred.
        low_idx = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (frame[i]) low_idx = 4'(i);
        low_code = {low_idx[1:0], low_idx[3:2]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cand         <= '0;
            cnt          <= '0;
            kb.key_value <= 4'd0;
            kb.key_flag  <= 1'b0;
            kb.key_valid <= 1'b0;
        end else begin
            kb.key_flag <= 1'b0;
            if (frame_done) begin
                case (state)
                    IDLE: begin
                        if (frame != 16'd0) begin
                            cand <= frame;
                            cnt  <= 8'd1;
                            if (DEBOUNCE_CNT == 8'd1) begin
                                state        <= HOLD;
                                kb.key_value <= low_code;
                                kb.key_valid <= 1'b1;
                                kb.key_flag  <= 1'b1;
                            end else begin
                                state <= PRESS_DB;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (frame == 16'd0) begin
                            state <= IDLE;
                            cnt   <= 8'd0;
                        end else if (frame == cand) begin
                            cnt <= cnt + 8'd1;
                            if (cnt + 8'd1 >= DEBOUNCE_CNT) begin
                                state        <= HOLD;
                                kb.key_value <= low_code;
                                kb.key_valid <= 1'b1;
                                kb.key_flag  <= 1'b1;
                            end
                        end else begin
                            cand <= frame;
                            cnt  <= 8'd1;
                        end
                    end
                    HOLD: begin
                        if (frame == 16'd0) begin
                            cnt <= 8'd1;
                            if (DEBOUNCE_CNT == 8'd1) begin
                                state        <= IDLE;
                                kb.key_valid <= 1'b0;
                            end else begin
                                state <= REL_DB;
                            end
                        end
                    end
                    default: begin // REL_DB
                        if (frame == 16'd0) begin
                            cnt <= cnt + 8'd1;
                            if (cnt + 8'd1 >= DEBOUNCE_CNT) begin
                                state        <= IDLE;
                                cnt          <= 8'd0;
                                kb.key_valid <= 1'b0;
                            end
                        end else begin
                            // A short release glitch: back to the held key, no new strobe.
                            state <= HOLD;
                        end
                    end
                endcase
            end
        end
    end

endmodule
